// File: rtl/time_frame_ctrl.sv
// time_frame_ctrl: receives {HEADER, hour, min, sec, csum} frames from a
// demodulated byte stream. It keeps a local 1-s timebase that is realigned
// whenever a good frame arrives, and flags loss of sync after TIMEOUT_S
// seconds without a good frame. dat_o always carries a self-consistent
// display frame for time_display.
//
// Byte handshake: byte_i is consumed on every rising clk edge where
// byte_vld_i=1, one byte per such cycle. There is no ready/backpressure path,
// so the block accepts every valid byte. Cycles with byte_vld_i=0 change
// nothing in the receive path, and the receive path has no inter-byte timeout.
module time_frame_ctrl #(
    parameter int          CLK_FREQ  = 50_000_000,
    parameter int          TIMEOUT_S = 3,
    parameter logic [7:0]  HEADER    = 8'hCC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_i,
    input  logic        byte_vld_i,
    output logic [39:0] dat_o,
    output logic        frm_ok_o,
    output logic        frm_err_o,
    output logic        lost_o,
    output logic [2:0]  state_dbg_o
);

    localparam int            TW         = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_FREQ - 1);
    localparam int            OW         = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
    localparam logic [OW-1:0] TO_LIMIT   = OW'(TIMEOUT_S);

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_HOUR = 3'd1,
        ST_MIN  = 3'd2,
        ST_SEC  = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [7:0]     stg_hour;
    logic [7:0]     stg_min;
    logic [7:0]     stg_sec;
    logic [7:0]     csum_exp;

    logic           frame_end;
    logic           frame_good;
    logic           frame_bad;

    logic [TW-1:0]  tick_cnt;
    logic           tick;

    logic [OW-1:0]  to_cnt;
    logic [OW-1:0]  to_cnt_inc;

    logic [7:0]     hour;
    logic [7:0]     minute;
    logic [7:0]     second;
    logic [7:0]     hour_nxt;
    logic [7:0]     minute_nxt;
    logic [7:0]     second_nxt;
    logic [7:0]     csum_nxt;

    assign state_dbg_o = state;

    // Receive FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Receive FSM next state: only a valid byte moves it. Once past the
    // header, a HEADER-valued byte is plain data and does not resync.
    always_comb begin
        state_nxt = state;
        if (byte_vld_i) begin
            case (state)
                ST_HUNT: if (byte_i == HEADER) state_nxt = ST_HOUR;
                ST_HOUR: state_nxt = ST_MIN;
                ST_MIN:  state_nxt = ST_SEC;
                ST_SEC:  state_nxt = ST_CSUM;
                ST_CSUM: state_nxt = ST_HUNT;
                default: state_nxt = ST_HUNT;
            endcase
        end
    end

    // Staging registers collect the fields of the frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_hour <= 8'h00;
            stg_min  <= 8'h00;
            stg_sec  <= 8'h00;
        end else if (byte_vld_i) begin
            case (state)
                ST_HOUR: stg_hour <= byte_i;
                ST_MIN:  stg_min  <= byte_i;
                ST_SEC:  stg_sec  <= byte_i;
                default: ;
            endcase
        end
    end

    // Frame verdict on the checksum byte: checksum and field ranges together.
    assign csum_exp   = HEADER + stg_hour + stg_min + stg_sec;
    assign frame_end  = byte_vld_i && (state == ST_CSUM);
    assign frame_good = frame_end && (byte_i == csum_exp) &&
                        (stg_hour < 8'd24) && (stg_min < 8'd60) && (stg_sec < 8'd60);
    assign frame_bad  = frame_end && !frame_good;

    // 1-s tick counter; a good frame realigns the second boundary to itself.
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (frame_good || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Next time of day: a frame load wins over a tick landing in the same cycle.
    always_comb begin
        hour_nxt   = hour;
        minute_nxt = minute;
        second_nxt = second;
        if (frame_good) begin
            hour_nxt   = stg_hour;
            minute_nxt = stg_min;
            second_nxt = stg_sec;
        end else if (tick) begin
            if (second == 8'd59) begin
                second_nxt = 8'd0;
                if (minute == 8'd59) begin
                    minute_nxt = 8'd0;
                    hour_nxt   = (hour == 8'd23) ? 8'd0 : hour + 8'd1;
                end else begin
                    minute_nxt = minute + 8'd1;
                end
            end else begin
                second_nxt = second + 8'd1;
            end
        end
    end

    assign csum_nxt = HEADER + hour_nxt + minute_nxt + second_nxt;

    // Time registers and the display frame update on the same edge, so dat_o
    // shows a newly loaded time in the cycle frm_ok_o is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            hour   <= 8'd0;
            minute <= 8'd0;
            second <= 8'd0;
            dat_o  <= {HEADER, 24'h000000, HEADER};
        end else begin
            hour   <= hour_nxt;
            minute <= minute_nxt;
            second <= second_nxt;
            dat_o  <= {HEADER, hour_nxt, minute_nxt, second_nxt, csum_nxt};
        end
    end

    // One-cycle verdict pulses, registered after the checksum byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            frm_ok_o  <= 1'b0;
            frm_err_o <= 1'b0;
        end else begin
            frm_ok_o  <= frame_good;
            frm_err_o <= frame_bad;
        end
    end

    // Loss-of-sync: seconds since the last good frame, saturating at the limit.
    // Bad frames leave it running; a good frame clears it alongside frm_ok_o.
    assign to_cnt_inc = to_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            lost_o <= 1'b0;
        end else if (frame_good) begin
            to_cnt <= '0;
            lost_o <= 1'b0;
        end else if (tick && (to_cnt != TO_LIMIT)) begin
            to_cnt <= to_cnt_inc;
            lost_o <= (to_cnt_inc == TO_LIMIT);
        end
    end

endmodule

// File: tb/tb_time_frame_ctrl.sv
// Bench for time_frame_ctrl with a fast timebase (10 clocks per second,
// 3-s loss timeout). Frame verdicts are checked through an expected queue.
module tb_time_frame_ctrl;

    localparam int          CLK_FREQ  = 10;
    localparam int          TIMEOUT_S = 3;
    localparam logic [7:0]  HDR       = 8'hCC;
    localparam logic [39:0] RST_DAT   = 40'hCC_00_00_00_CC;
    localparam logic [2:0]  ST_HUNT   = 3'd0;

    logic        clk;
    logic        rst;
    logic [7:0]  byte_i;
    logic        byte_vld_i;
    logic [39:0] dat_o;
    logic        frm_ok_o;
    logic        frm_err_o;
    logic        lost_o;
    logic [2:0]  state_dbg_o;

    int          checks   = 0;
    int          failures = 0;
    logic [41:0] exp_q[$];
    logic [41:0] mon_e;
    logic [39:0] last_dat;

    time_frame_ctrl #(
        .CLK_FREQ  (CLK_FREQ),
        .TIMEOUT_S (TIMEOUT_S),
        .HEADER    (HDR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_i      (byte_i),
        .byte_vld_i  (byte_vld_i),
        .dat_o       (dat_o),
        .frm_ok_o    (frm_ok_o),
        .frm_err_o   (frm_err_o),
        .lost_o      (lost_o),
        .state_dbg_o (state_dbg_o)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reset for two edges; returns 1 time unit after the last reset edge.
    task automatic do_reset();
        rst        = 1'b1;
        byte_vld_i = 1'b0;
        byte_i     = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        last_dat = RST_DAT;
    endtask

    // Optional idle cycles, then one valid byte sampled on the next edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        byte_vld_i = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        byte_i     = b;
        byte_vld_i = 1'b1;
        @(posedge clk);
        #1;
        byte_vld_i = 1'b0;
    endtask

    // Sends a full frame and queues the verdict the frame should produce.
    task automatic send_frame(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                              input logic [7:0] c, input int max_gap);
        logic        ok;
        logic [41:0] e;
        ok = (c == 8'(HDR + h + m + s)) && (h < 8'd24) && (m < 8'd60) && (s < 8'd60);
        send_byte(HDR, $urandom_range(0, max_gap));
        send_byte(h,   $urandom_range(0, max_gap));
        send_byte(m,   $urandom_range(0, max_gap));
        send_byte(s,   $urandom_range(0, max_gap));
        if (ok) begin
            last_dat = {HDR, h, m, s, c};
            e = {2'b10, last_dat};
        end else begin
            e = {2'b01, last_dat};
        end
        exp_q.push_back(e);
        send_byte(c, $urandom_range(0, max_gap));
    endtask

    // Scoreboard: every verdict pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && (frm_ok_o || frm_err_o)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {frm_ok_o, frm_err_o}, 2'b00);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", {frm_ok_o, frm_err_o}, mon_e[41:40]);
                check("frame_dat", dat_o, mon_e[39:0]);
            end
        end
    end

    // watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] h, m, s, c;

        do_reset();
        check("rst_dat",   dat_o,       RST_DAT);
        check("rst_ok",    frm_ok_o,    1'b0);
        check("rst_err",   frm_err_o,   1'b0);
        check("rst_lost",  lost_o,      1'b0);
        check("rst_state", state_dbg_o, ST_HUNT);

        // basic good frame, then bad checksum
        send_frame(8'h17, 8'h18, 8'h19, 8'h14, 0);
        check("lost_after_ok", lost_o, 1'b0);
        send_frame(8'h17, 8'h18, 8'h19, 8'h15, 0);
        check("state_after_err", state_dbg_o, ST_HUNT);

        // leading garbage ignored
        send_byte(8'h00, 0);
        send_byte(8'h55, 0);
        send_frame(8'h17, 8'h18, 8'h19, 8'h14, 0);

        // range boundaries, each bad frame directly after a good load
        send_frame(8'h18, 8'h00, 8'h00, 8'hE4, 0);
        send_frame(8'h00, 8'h3B, 8'h00, 8'h07, 0);
        send_frame(8'h00, 8'h00, 8'h3C, 8'h08, 0);
        send_frame(8'h00, 8'h00, 8'h3B, 8'h07, 0);
        send_frame(8'h00, 8'h3C, 8'h00, 8'h08, 0);
        send_frame(8'h17, 8'h00, 8'h00, 8'hE3, 0);
        // header value inside the frame is data
        send_frame(8'h01, HDR, 8'h02, 8'h9B, 0);
        check("state_after_hdr_data", state_dbg_o, ST_HUNT);

        // random good frames with idle gaps, some followed by a bad checksum
        for (int i = 0; i < 8; i++) begin
            h = 8'($urandom_range(0, 23));
            m = 8'($urandom_range(0, 59));
            s = 8'($urandom_range(0, 59));
            c = 8'(HDR + h + m + s);
            send_frame(h, m, s, c, 3);
            if ($urandom_range(0, 1) == 1) send_frame(h, m, s, c + 8'd1, 0);
        end

        // midnight rollover ten clocks after loading 23:59:59
        send_frame(8'h17, 8'h3B, 8'h3B, 8'h59, 0);
        repeat (9) @(posedge clk);
        #1;
        check("pre_wrap_dat", dat_o, 40'hCC_17_3B_3B_59);
        @(posedge clk);
        #1;
        check("wrap_dat", dat_o, RST_DAT);

        // reset in the middle of a frame aborts it silently
        send_byte(HDR, 0);
        send_byte(8'h17, 0);
        send_byte(8'h18, 0);
        do_reset();
        check("midrst_state", state_dbg_o, ST_HUNT);
        check("midrst_dat",   dat_o,       RST_DAT);
        send_byte(8'h19, 0);
        send_byte(8'h14, 0);
        check("midrst_tail_state", state_dbg_o, ST_HUNT);

        // loss of sync: a bad frame does not hold it off, good frame clears it
        do_reset();
        send_frame(8'h01, 8'h02, 8'h03, 8'h00, 0);
        repeat (24) @(posedge clk);
        #1;
        check("lost_before_limit", lost_o, 1'b0);
        @(posedge clk);
        #1;
        check("lost_at_limit", lost_o, 1'b1);
        check("time_while_lost", dat_o, 40'hCC_00_00_03_CF);
        send_frame(8'h01, 8'h02, 8'h03, 8'hD2, 0);
        check("lost_cleared", lost_o, 1'b0);
        check("ok_with_clear", frm_ok_o, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
